// File: rtl/floor_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : floor_call_dispatcher
// Description : Debounces floor call buttons into a pending mask and issues
//               one round-robin floor request at a time to the car controller.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_call_dispatcher #(
    parameter int NUM_FLOORS     = 8,
    parameter int DEB_TICK       = 1000,
    parameter int ACCEPT_TIMEOUT = 64,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  complete,
    input  logic [2:0]            out_floor,
    input  logic                  over_weight,
    output logic [2:0]            req_floor,
    output logic [NUM_FLOORS-1:0] call_lamp,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int TICK_W = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
    localparam int ACC_W  = $clog2(ACCEPT_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_ACCEPT = 3'd1,
        WAIT_ARRIVE = 3'd2,
        SERVED      = 3'd3,
        GAP         = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [NUM_FLOORS-1:0]   sync1;
    logic [NUM_FLOORS-1:0]   sync2;
    logic [NUM_FLOORS-1:0]   hist0;
    logic [NUM_FLOORS-1:0]   hist1;
    logic [NUM_FLOORS-1:0]   stable;
    logic [NUM_FLOORS-1:0]   stable_q;
    logic [NUM_FLOORS-1:0]   press;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;

    logic [NUM_FLOORS-1:0]   pending;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [2:0]              ptr;
    logic [2:0]              sel;
    logic [3:0]              cand;
    logic                    found;

    logic [ACC_W-1:0]        acc_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    load_req;
    logic                    serve;
    logic                    to_fire;

    // ------------------------------------------------------------------
    // Synchroniser and tick-sampled debounce
    // ------------------------------------------------------------------
    assign tick   = (tick_cnt == TICK_W'(DEB_TICK - 1));
    assign stable = hist0 & hist1;
    assign press  = stable & ~stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            hist0    <= '0;
            hist1    <= '0;
            stable_q <= '0;
            tick_cnt <= '0;
        end else begin
            sync1    <= call_btn;
            sync2    <= sync1;
            stable_q <= stable;
            if (tick) begin
                tick_cnt <= '0;
                hist0    <= sync2;
                hist1    <= hist0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending mask update: a same-cycle clear beats a new press
    // ------------------------------------------------------------------
    always_comb begin
        set_mask    = press;
        set_mask[0] = 1'b0;
        if (state == IDLE && complete)
            set_mask[out_floor] = 1'b0;
        clear_mask = '0;
        if (serve)
            clear_mask[req_floor] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending | set_mask) & ~clear_mask;
    end

    // ------------------------------------------------------------------
    // Round-robin search: ptr+1 .. 7, wrapping through 1 .. ptr
    // ------------------------------------------------------------------
    always_comb begin
        sel   = 3'd0;
        found = 1'b0;
        cand  = 4'd0;
        for (int k = 1; k < 8; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand > 4'd7)
                cand = cand - 4'd7;
            if (!found && pending[cand[2:0]]) begin
                sel   = cand[2:0];
                found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        serve      = 1'b0;
        to_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0 && !over_weight) begin
                    load_req   = 1'b1;
                    state_next = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (!complete)
                    state_next = WAIT_ARRIVE;
                else if (out_floor == req_floor)
                    state_next = SERVED;
                else if (acc_cnt == ACC_W'(ACCEPT_TIMEOUT - 1)) begin
                    to_fire    = 1'b1;
                    state_next = GAP;
                end
            end
            WAIT_ARRIVE: begin
                if (!over_weight && complete && out_floor == req_floor)
                    state_next = SERVED;
            end
            SERVED: begin
                serve      = 1'b1;
                state_next = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_floor   <= 3'd0;
            ptr         <= 3'd0;
            acc_cnt     <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_fire;
            if (load_req)
                req_floor <= sel;
            else if (serve || to_fire)
                req_floor <= 3'd0;
            if (serve)
                ptr <= req_floor;
            acc_cnt <= (state == WAIT_ACCEPT) ? acc_cnt + 1'b1 : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    assign call_lamp = pending;
    assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_floor_call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_call_dispatcher
// Description : Directed scoreboard bench for floor_call_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_call_dispatcher;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] call_btn;
    logic       complete;
    logic [2:0] out_floor;
    logic       over_weight;
    logic [2:0] req_floor;
    logic [7:0] call_lamp;
    logic       busy;
    logic       timeout_err;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [2:0] exp_q[$];

    floor_call_dispatcher #(
        .NUM_FLOORS     (8),
        .DEB_TICK       (DEB),
        .ACCEPT_TIMEOUT (64),
        .GAP_CYCLES     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .call_btn    (call_btn),
        .complete    (complete),
        .out_floor   (out_floor),
        .over_weight (over_weight),
        .req_floor   (req_floor),
        .call_lamp   (call_lamp),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounce the masked buttons every cycle, then hold them high
    task automatic press_mask(input logic [7:0] m);
        for (int i = 0; i < 3 * DEB; i++) begin
            call_btn = call_btn ^ m;
            @(negedge clk);
        end
        call_btn = call_btn | m;
    endtask

    task automatic wait_lamp(input string tag, input logic [7:0] exp, input int bound);
        int n;
        n = 0;
        while (call_lamp !== exp && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(call_lamp), 32'(exp));
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Pops the scoreboard when the next request appears on req_floor
    task automatic wait_issue(input string tag, input int bound);
        int n;
        logic [2:0] exp;
        n = 0;
        while (req_floor === 3'd0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        check(tag, 32'(req_floor), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset       = 1'b1;
        call_btn    = 8'h00;
        complete    = 1'b1;
        out_floor   = 3'd1;
        over_weight = 1'b0;

        // Reset / idle
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_req",  32'(req_floor),   32'd0);
        check("rst_lamp", 32'(call_lamp),   32'd0);
        check("rst_busy", 32'(busy),        32'd0);
        check("rst_tmo",  32'(timeout_err), 32'd0);

        // Single call to floor 5 with bounce, held afterwards
        press_mask(8'h20);
        wait_lamp("single_lamp", 8'h20, 60);
        exp_q.push_back(3'd5);
        wait_issue("single_req", 20);
        check("single_busy", 32'(busy), 32'd1);
        tick(2);
        complete = 1'b0;
        tick(5);
        check("single_stable", 32'(req_floor), 32'd5);
        out_floor = 3'd5;
        complete  = 1'b1;
        wait_lamp("single_clear", 8'h00, 10);
        check("gap_req0", 32'(req_floor), 32'd0);
        tick(1);
        check("gap_req1", 32'(req_floor), 32'd0);
        wait_idle("single_idle", 10);
        tick(40);
        check("hold_one_event_lamp", 32'(call_lamp), 32'd0);
        check("hold_one_event_req",  32'(req_floor), 32'd0);
        call_btn = 8'h00;
        tick(20);

        // Overload holds floor 3, release issues it next cycle
        over_weight = 1'b1;
        press_mask(8'h08);
        wait_lamp("ovl_lamp", 8'h08, 60);
        tick(5);
        check("ovl_hold", 32'(req_floor), 32'd0);
        over_weight = 1'b0;
        exp_q.push_back(3'd3);
        wait_issue("ovl_release", 1);
        tick(2);
        complete = 1'b0;
        tick(3);
        out_floor = 3'd3;
        complete  = 1'b1;
        wait_idle("ovl_idle", 20);
        call_btn = 8'h00;
        tick(20);

        // Round-robin from ptr 3: pending {2,6} -> 6 then 2, then repeat of 6
        over_weight = 1'b1;
        press_mask(8'h44);
        wait_lamp("rr_lamp", 8'h44, 60);
        over_weight = 1'b0;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd2);
        wait_issue("rr_first", 5);
        tick(2);
        complete = 1'b0;
        call_btn = 8'h00;
        tick(3);
        out_floor = 3'd6;
        complete  = 1'b1;
        wait_lamp("rr_clear6", 8'h04, 10);
        wait_issue("rr_second", 20);
        tick(2);
        complete = 1'b0;
        tick(20);
        press_mask(8'h40);
        wait_lamp("rr_repress", 8'h44, 60);
        exp_q.push_back(3'd6);
        out_floor = 3'd2;
        complete  = 1'b1;
        wait_lamp("rr_clear2", 8'h40, 10);
        check("rr_gap", 32'(req_floor), 32'd0);
        wait_issue("rr_repeat", 20);
        out_floor = 3'd6;
        wait_idle("rr_idle", 20);
        check("rr_lamp_end", 32'(call_lamp), 32'd0);
        call_btn = 8'h00;
        tick(20);

        // Timeout: floor 4 issued while complete sticks high at floor 1
        out_floor   = 3'd1;
        over_weight = 1'b1;
        press_mask(8'h10);
        wait_lamp("tmo_lamp", 8'h10, 60);
        call_btn    = 8'h00;
        over_weight = 1'b0;
        exp_q.push_back(3'd4);
        wait_issue("tmo_issue", 1);
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_cycle", 32'(cyc), 32'd64);
        check("tmo_req0",  32'(req_floor), 32'd0);
        check("tmo_keep",  32'(call_lamp), 32'h10);
        tick(1);
        check("tmo_pulse", 32'(timeout_err), 32'd0);
        exp_q.push_back(3'd4);
        wait_issue("tmo_reissue", 10);
        out_floor = 3'd4;
        wait_idle("tmo_idle", 20);
        check("tmo_lamp_end", 32'(call_lamp), 32'd0);
        tick(10);

        // Reset during WAIT_ARRIVE, then press of the floor the car sits at
        press_mask(8'h80);
        wait_lamp("mid_lamp", 8'h80, 60);
        exp_q.push_back(3'd7);
        wait_issue("mid_issue", 10);
        tick(2);
        complete = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("mid_req",  32'(req_floor),   32'd0);
        check("mid_lamp0", 32'(call_lamp),  32'd0);
        check("mid_busy", 32'(busy),        32'd0);
        check("mid_tmo",  32'(timeout_err), 32'd0);
        reset     = 1'b0;
        out_floor = 3'd7;
        complete  = 1'b1;
        tick(40);
        check("ignore_lamp", 32'(call_lamp), 32'd0);
        check("ignore_busy", 32'(busy),      32'd0);
        call_btn = 8'h00;
        tick(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floor_call_dispatcher.md
Name: floor_call_dispatcher

Overview:
- Request-issuing end of the elevator controller's `req_floor`/`complete`/`out_floor` interface.
- Debounces raw floor call buttons and latches them into a pending mask.
- Drives one floor request at a time onto `req_floor`, waits for the car to arrive, clears the call, then issues the next call in round-robin order.
- Sits between the floor button panel and the elevator controller; also drives the call lamps.

Parameters:
- `NUM_FLOORS`, 8, number of floor positions. Floor 0 is reserved as "no request". Only 8 is supported.
- `DEB_TICK`, 1000, clk cycles between debounce samples. Must be at least 1.
- `ACCEPT_TIMEOUT`, 64, maximum clk cycles to wait for the controller to drop `complete` after a request is issued.
- `GAP_CYCLES`, 2, clk cycles `req_floor` is held at 0 between requests.

Ports:
- `clk`, input, 1, system clock.
- `reset`, input, 1, synchronous reset, active-high.
- `call_btn`, input, 8, raw asynchronous buttons; bit f means floor f; bit 0 is ignored.
- `complete`, input, 1, controller's complete flag.
- `out_floor`, input, 3, controller's current floor.
- `over_weight`, input, 1, controller's overload flag.
- `req_floor`, output, 3, request to the controller; 0 means none.
- `call_lamp`, output, 8, pending-call lamps; equal to the pending mask.
- `busy`, output, 1, high whenever state is not IDLE.
- `timeout_err`, output, 1, one-cycle pulse when an issued request is not accepted in time.

Behaviour:
- Reset, applied at any time including mid-request:
  - state = IDLE; pending, `call_lamp`, `req_floor`, `busy`, `timeout_err` = 0.
  - Debounce history cleared; round-robin pointer = 0.
- Input synchronisation: `call_btn` passes through a 2-flop synchroniser.
- Debounce:
  - A free-running tick counter samples the synchronised buttons every `DEB_TICK` cycles into a 2-deep history per bit.
  - A button is stable-high when both samples are 1.
  - A press event is a rising edge of the stable-high value. Holding a button produces exactly one event.
- Pending mask:
  - `pending[f]` is set on a press event for f = 1..7.
  - A press is ignored if f equals `out_floor` while state is IDLE and `complete` = 1 (car already there).
  - Bit 0 is never set.
  - An already-set bit stays set; there is no double-counting.
- Selection:
  - Round-robin. Search starts at (ptr+1) and runs upward through 7, wraps to 1, and ends at ptr.
  - The first pending floor found is selected.
  - ptr updates to the served floor at SERVED.
- FSM states: IDLE, WAIT_ACCEPT, WAIT_ARRIVE, SERVED, GAP.
  - **IDLE:** if pending != 0 and `over_weight` = 0, register `req_floor` = selected floor and go to WAIT_ACCEPT next cycle. Otherwise stay, with `req_floor` = 0.
  - **WAIT_ACCEPT:**
    - `complete` = 0 → WAIT_ARRIVE.
    - `complete` = 1 and `out_floor` == `req_floor` (served without moving) → SERVED.
    - After `ACCEPT_TIMEOUT` cycles with neither → pulse `timeout_err`, keep the pending bit, go to GAP.
  - **WAIT_ARRIVE:** `complete` = 1 and `out_floor` == `req_floor` → SERVED. No timeout in this state. `over_weight` = 1 freezes the state with no error.
  - **SERVED** (1 cycle): clear `pending[req_floor]`, ptr = `req_floor`, `req_floor` <= 0, go to GAP.
  - **GAP:** hold `req_floor` = 0 for `GAP_CYCLES` cycles, then IDLE. This guarantees the value changes between requests, including a repeat of the same floor.
- `req_floor` is stable for the whole of WAIT_ACCEPT/WAIT_ARRIVE. Calls arriving during service only set pending bits.
- Simultaneous events:
  - A press of floor f in the same cycle as SERVED clears f: the clear wins and the press is dropped.
  - Presses of other floors in that cycle are kept.
- `busy` = (state != IDLE), combinational from the state register.
- Latency:
  - Press event to `call_lamp` set: 1 cycle.
  - IDLE with pending to `req_floor` valid: 1 cycle.

Test Plan:
- **Reset/idle:** assert `reset` 3 cycles with `call_btn` = 0 → `req_floor` = 0, `call_lamp` = 0, `busy` = 0.
- **Single call:**
  - Stimulus: `out_floor` = 1; press btn 5 with 3-tick bounce then hold.
  - Required: exactly one event; `call_lamp` = 8'b0010_0000; `req_floor` = 5.
  - Model drops `complete`, later `complete` = 1 with `out_floor` = 5 → lamp bit clears, `req_floor` = 0 for 2 cycles, `busy` = 0.
- **Round-robin:** pending {2,6} with ptr = 3 → 6 is issued first, then 2. The pressed-again repeat of 6 is reissued after GAP.
- **Timeout:** issue floor 4; `complete` stuck at 1 with `out_floor` = 1 → `timeout_err` pulses at cycle 64. Bit 4 stays pending and floor 4 is reissued after GAP.
- **Overload:** `over_weight` = 1 with pending {3} → `req_floor` stays 0. Deassert → `req_floor` = 3 next cycle.
- **Reset mid-operation:** `reset` during WAIT_ARRIVE → next cycle all outputs 0. Floor already reached with `complete` = 1 → new press of that floor is ignored.
